// File: rtl/vga_pkg.sv
// Shared VGA definitions: 640x480 timing, coordinate widths,
// lock FSM states and saturating-increment helpers.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_TOTAL  = 800;
    localparam int V_ACTIVE = 480;
    localparam int V_TOTAL  = 525;

    localparam int COORD_W = 10;
    localparam int MEAS_W  = 11;

    typedef enum logic [1:0] {
        ST_UNLOCKED,
        ST_TRACK,
        ST_LOCKED
    } lock_state_e;

    function automatic logic [MEAS_W-1:0] sat_inc_m(
        input logic [MEAS_W-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [COORD_W-1:0] sat_inc_c(
        input logic [COORD_W-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/vga_edge_sync.sv
// Stage-1 capture of hsync/vsync/de with a delayed copy,
// producing single-cycle edge pulses for the detector.
module vga_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic hs_i,
    input  logic vs_i,
    input  logic de_i,
    output logic de_o,
    output logic hs_fall_o,
    output logic vs_fall_o,
    output logic de_rise_o,
    output logic de_fall_o
);

    logic hs_q, vs_q, de_q;
    logic hs_p_q, vs_p_q, de_p_q;

    // Sample pins and keep the previous sample for edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hs_q   <= 1'b0;
            vs_q   <= 1'b0;
            de_q   <= 1'b0;
            hs_p_q <= 1'b0;
            vs_p_q <= 1'b0;
            de_p_q <= 1'b0;
        end else begin
            hs_q   <= hs_i;
            vs_q   <= vs_i;
            de_q   <= de_i;
            hs_p_q <= hs_q;
            vs_p_q <= vs_q;
            de_p_q <= de_q;
        end
    end

    assign de_o      = de_q;
    assign hs_fall_o = hs_p_q & ~hs_q;
    assign vs_fall_o = vs_p_q & ~vs_q;
    assign de_rise_o = ~de_p_q & de_q;
    assign de_fall_o = de_p_q & ~de_q;

endmodule

// File: rtl/vga_timing_detector.sv
// Recovers pixel coordinates from hs/vs/de, measures line and
// frame geometry and tracks lock against the expected timing.
module vga_timing_detector
    import vga_pkg::*;
#(
    parameter int PIXELS_H    = H_ACTIVE,
    parameter int PIXELS_V    = V_ACTIVE,
    parameter int TOTAL_H     = H_TOTAL,
    parameter int TOTAL_V     = V_TOTAL,
    parameter int LOCK_FRAMES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               vga_hs,
    input  logic               vga_vs,
    input  logic               de,
    output logic               pix_valid,
    output logic [COORD_W-1:0] px,
    output logic [COORD_W-1:0] py,
    output logic               frame_start,
    output logic [MEAS_W-1:0]  h_total,
    output logic [MEAS_W-1:0]  v_total,
    output logic [COORD_W-1:0] h_active,
    output logic [COORD_W-1:0] v_active,
    output logic               locked,
    output logic               sync_err
);

    localparam logic [MEAS_W-1:0]  EXP_HT = MEAS_W'(TOTAL_H);
    localparam logic [MEAS_W-1:0]  EXP_VT = MEAS_W'(TOTAL_V);
    localparam logic [COORD_W-1:0] EXP_HA = COORD_W'(PIXELS_H);
    localparam logic [COORD_W-1:0] EXP_VA = COORD_W'(PIXELS_V);
    localparam logic [7:0]         LOCK_N = 8'(LOCK_FRAMES);

    logic de_s1, hs_fall, vs_fall, de_rise, de_fall;

    logic [MEAS_W-1:0]  hcnt_q, hcnt_d;
    logic [MEAS_W-1:0]  lines_q, lines_d;
    logic [MEAS_W-1:0]  h_total_q, h_total_d;
    logic [MEAS_W-1:0]  v_total_q, v_total_d;
    logic [COORD_W-1:0] px_q, px_d;
    logic [COORD_W-1:0] py_q, py_d;
    logic [COORD_W-1:0] act_q, act_d;
    logic [COORD_W-1:0] h_active_q, h_active_d;
    logic [COORD_W-1:0] v_active_q, v_active_d;
    logic               pv_q, pv_d;
    logic               fs_q, fs_d;
    logic               se_q, se_d;
    logic               seen_q, seen_d;
    logic               first_q, first_d;
    lock_state_e        state_q, state_d;
    logic [7:0]         good_q, good_d;
    logic               match;

    vga_edge_sync u_edge (
        .clk       (clk),
        .rst_n     (rst_n),
        .hs_i      (vga_hs),
        .vs_i      (vga_vs),
        .de_i      (de),
        .de_o      (de_s1),
        .hs_fall_o (hs_fall),
        .vs_fall_o (vs_fall),
        .de_rise_o (de_rise),
        .de_fall_o (de_fall)
    );

    // Geometry counters and coordinates; vs is applied before de
    always_comb begin
        hcnt_d     = sat_inc_m(hcnt_q);
        h_total_d  = h_total_q;
        lines_d    = lines_q;
        v_total_d  = v_total_q;
        px_d       = px_q;
        py_d       = py_q;
        act_d      = act_q;
        h_active_d = h_active_q;
        v_active_d = v_active_q;
        seen_d     = seen_q;
        first_d    = first_q;
        fs_d       = 1'b0;

        if (hs_fall) begin
            h_total_d = sat_inc_m(hcnt_q);
            hcnt_d    = '0;
            lines_d   = sat_inc_m(lines_q);
        end

        if (vs_fall) begin
            v_total_d  = lines_d;
            lines_d    = '0;
            v_active_d = act_q;
            act_d      = '0;
            fs_d       = 1'b1;
            seen_d     = 1'b1;
            first_d    = 1'b1;
            py_d       = '0;
        end

        if (de_rise) begin
            px_d    = '0;
            py_d    = first_d ? '0 : sat_inc_c(py_d);
            first_d = 1'b0;
            act_d   = sat_inc_c(act_d);
        end else if (de_s1) begin
            px_d = sat_inc_c(px_q);
        end

        if (de_fall) begin
            h_active_d = sat_inc_c(px_q);
        end

        pv_d = de_s1 & seen_d;
    end

    assign match = (h_total_d == EXP_HT) &&
                   (v_total_d == EXP_VT) &&
                   (h_active_d == EXP_HA) &&
                   (v_active_d == EXP_VA);

    // Lock FSM next state, evaluated once per completed frame
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        se_d    = 1'b0;
        if (vs_fall && seen_q) begin
            unique case (state_q)
                ST_UNLOCKED: begin
                    if (match) begin
                        good_d  = 8'd1;
                        state_d = (LOCK_N <= 8'd1) ? ST_LOCKED
                                                   : ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    if (match) begin
                        good_d = good_q + 8'd1;
                        if (good_d >= LOCK_N) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        good_d  = '0;
                        state_d = ST_UNLOCKED;
                        se_d    = 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (!match) begin
                        good_d  = '0;
                        state_d = ST_UNLOCKED;
                        se_d    = 1'b1;
                    end
                end
                default: begin
                    good_d  = '0;
                    state_d = ST_UNLOCKED;
                end
            endcase
        end
    end

    // State register for counters, outputs and the lock FSM
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hcnt_q     <= '0;
            lines_q    <= '0;
            h_total_q  <= '0;
            v_total_q  <= '0;
            px_q       <= '0;
            py_q       <= '0;
            act_q      <= '0;
            h_active_q <= '0;
            v_active_q <= '0;
            pv_q       <= 1'b0;
            fs_q       <= 1'b0;
            se_q       <= 1'b0;
            seen_q     <= 1'b0;
            first_q    <= 1'b0;
            state_q    <= ST_UNLOCKED;
            good_q     <= '0;
        end else begin
            hcnt_q     <= hcnt_d;
            lines_q    <= lines_d;
            h_total_q  <= h_total_d;
            v_total_q  <= v_total_d;
            px_q       <= px_d;
            py_q       <= py_d;
            act_q      <= act_d;
            h_active_q <= h_active_d;
            v_active_q <= v_active_d;
            pv_q       <= pv_d;
            fs_q       <= fs_d;
            se_q       <= se_d;
            seen_q     <= seen_d;
            first_q    <= first_d;
            state_q    <= state_d;
            good_q     <= good_d;
        end
    end

    assign pix_valid   = pv_q;
    assign px          = px_q;
    assign py          = py_q;
    assign frame_start = fs_q;
    assign h_total     = h_total_q;
    assign v_total     = v_total_q;
    assign h_active    = h_active_q;
    assign v_active    = v_active_q;
    assign locked      = (state_q == ST_LOCKED);
    assign sync_err    = se_q;

endmodule

// File: tb/tb_vga_timing_detector.sv
// Bench for vga_timing_detector: randomized frame geometry checked
// against a pin-event reference model with 2-cycle output latency.
module tb_vga_timing_detector;

    localparam int PH = 40;
    localparam int PV = 20;
    localparam int TH = 64;
    localparam int TV = 30;
    localparam int LF = 2;
    localparam int HS = 48;
    localparam int HW = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vga_hs = 1'b1;
    logic       vga_vs = 1'b1;
    logic       de = 1'b0;
    logic       pix_valid;
    logic [9:0] px, py;
    logic       frame_start;
    logic [10:0] h_total, v_total;
    logic [9:0] h_active, v_active;
    logic       locked, sync_err;

    always #5 clk = ~clk;

    vga_timing_detector #(
        .PIXELS_H    (PH),
        .PIXELS_V    (PV),
        .TOTAL_H     (TH),
        .TOTAL_V     (TV),
        .LOCK_FRAMES (LF)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .de          (de),
        .pix_valid   (pix_valid),
        .px          (px),
        .py          (py),
        .frame_start (frame_start),
        .h_total     (h_total),
        .v_total     (v_total),
        .h_active    (h_active),
        .v_active    (v_active),
        .locked      (locked),
        .sync_err    (sync_err)
    );

    typedef struct {
        bit pv;
        int px;
        int py;
        bit fs;
        bit se;
        bit lk;
        bit geo;
        int ht;
        int vt;
        int ha;
        int va;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    bit   rst_now = 1'b0;
    bit   in_rst = 1'b1;

    int t = 0;
    bit p_hs, p_vs, p_de, have_hs, seen;
    int last_hs, ht_m, ha_m, hs_n, rises, de_t0, run;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic chk(input string tag, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d at %0t",
                     tag, got, want, $time);
        end
    endtask

    function automatic void model_reset();
        p_hs = 1'b0; p_vs = 1'b0; p_de = 1'b0;
        have_hs = 1'b0; seen = 1'b0;
        last_hs = 0; ht_m = 0; ha_m = 0;
        hs_n = 0; rises = 0; de_t0 = 0; run = 0;
    endfunction

    // Pin-level reference: events ordered hs, de_fall, vs, de_rise
    task automatic model(input bit hs, input bit vs, input bit d,
                         output exp_t e);
        bit match;
        e = '{default: 0};
        if (p_hs && !hs) begin
            if (have_hs) ht_m = imin(t - last_hs, 2047);
            last_hs = t;
            have_hs = 1'b1;
            hs_n++;
        end
        if (p_de && !d) ha_m = imin(t - de_t0, 1023);
        if (p_vs && !vs) begin
            e.fs = 1'b1;
            if (seen) begin
                e.geo = 1'b1;
                e.ht  = ht_m;
                e.vt  = imin(hs_n, 2047);
                e.ha  = ha_m;
                e.va  = imin(rises, 1023);
                match = (e.ht == TH) && (e.vt == TV) &&
                        (e.ha == PH) && (e.va == PV);
                e.se  = !match && (run > 0);
                run   = match ? run + 1 : 0;
            end
            seen  = 1'b1;
            hs_n  = 0;
            rises = 0;
        end
        if (!p_de && d) begin
            de_t0 = t;
            rises++;
        end
        e.lk = (run >= LF);
        e.pv = d && seen;
        e.px = imin(t - de_t0, 1023);
        e.py = rises - 1;
        p_hs = hs; p_vs = vs; p_de = d;
        t++;
    endtask

    task automatic compare(input exp_t x);
        chk("pix_valid", int'(pix_valid), int'(x.pv));
        if (x.pv) begin
            chk("px", int'(px), x.px);
            chk("py", int'(py), x.py);
        end
        chk("frame_start", int'(frame_start), int'(x.fs));
        chk("sync_err", int'(sync_err), int'(x.se));
        chk("locked", int'(locked), int'(x.lk));
        if (x.geo) begin
            chk("h_total", int'(h_total), x.ht);
            chk("v_total", int'(v_total), x.vt);
            chk("h_active", int'(h_active), x.ha);
            chk("v_active", int'(v_active), x.va);
        end
    endtask

    task automatic check_zero();
        chk("rst_pix_valid", int'(pix_valid), 0);
        chk("rst_px", int'(px), 0);
        chk("rst_py", int'(py), 0);
        chk("rst_frame_start", int'(frame_start), 0);
        chk("rst_h_total", int'(h_total), 0);
        chk("rst_v_total", int'(v_total), 0);
        chk("rst_h_active", int'(h_active), 0);
        chk("rst_v_active", int'(v_active), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_sync_err", int'(sync_err), 0);
    endtask

    // One pixel clock of stimulus; outputs checked 2 cycles later
    task automatic tick(input bit hs, input bit vs, input bit d);
        exp_t e;
        @(negedge clk);
        if (in_rst) begin
            check_zero();
            rst_n  = 1'b1;
            in_rst = 1'b0;
            q.delete();
            model_reset();
        end else if (q.size() == 2) begin
            compare(q.pop_front());
        end
        vga_hs = hs;
        vga_vs = vs;
        de     = d;
        if (rst_now) begin
            rst_now = 1'b0;
            rst_n   = 1'b0;
            in_rst  = 1'b1;
            q.delete();
        end else begin
            model(hs, vs, d, e);
            q.push_back(e);
        end
    endtask

    // Frame starts with vs low for 2 lines; active lines from vb
    task automatic run_frame(input int L, input int A, input int VA,
                             input int V, input int vb, input int xl,
                             input int rl, input int rc);
        for (int l = 0; l < V; l++) begin
            int len;
            bit act;
            len = (l == V - 2) ? L + xl : L;
            act = (l >= vb) && (l < vb + VA);
            for (int c = 0; c < len; c++) begin
                if (l == rl && c == rc) rst_now = 1'b1;
                tick(!(c >= HS && c < HS + HW), !(l < 2), act && (c < A));
            end
        end
    endtask

    task automatic nominal();
        run_frame(TH, PH, PV, TV, 4, 0, -1, 0);
    endtask

    task automatic rand_frame();
        int L, A, VA, V, vb, xl, dlt;
        L = TH; A = PH; VA = PV; V = TV; vb = 4; xl = 0;
        dlt = ($urandom_range(0, 1) == 1) ? 1 : -1;
        case ($urandom_range(0, 6))
            0: L  = TH + dlt;
            1: A  = PH + dlt;
            2: VA = PV + dlt;
            3: V  = TV + dlt;
            4: xl = int'($urandom_range(1, 3));
            5: vb = 0;
            default: ;
        endcase
        run_frame(L, A, VA, V, vb, xl, -1, 0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        for (int l = 0; l < 3; l++) begin
            for (int c = 0; c < TH; c++) begin
                tick(!(c >= HS && c < HS + HW), 1'b1, c < PH);
            end
        end
        repeat (3) nominal();
        run_frame(TH, PH, PV, TV, 4, 1, -1, 0);
        repeat (3) nominal();
        run_frame(TH, PH, PV, TV, 4, 0, 10, 20);
        repeat (3) nominal();
        run_frame(TH, PH, PV, TV, 0, 0, -1, 0);
        run_frame(TH, PH, PV, TV, 4, 3000 - TH, -1, 0);
        repeat (2) nominal();
        repeat (10) rand_frame();
        nominal();
        repeat (2) tick(1'b1, 1'b1, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
